// File: rtl/sram_axi_req_arbiter_pkg.sv
// Shared definitions for the SRAM-to-AXI bridge: fixed AXI IDs, AXI size
// encodings and the issue-slot payload layouts used by the request arbiter
// and by the AR/R and AW/W/B channel blocks.
package bridge_pkg;

    localparam logic [3:0] INST_ID = 4'd0;
    localparam logic [3:0] DATA_ID = 4'd1;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [2:0]  size;
    } rd_slot_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } wr_slot_t;

    // SRAM-like size (bytes = 1 << size) maps directly onto AWSIZE/ARSIZE.
    function automatic logic [2:0] axi_size(input logic [1:0] sram_size);
        return {1'b0, sram_size};
    endfunction

endpackage

// File: rtl/sram_axi_req_arbiter_if.sv
// Request/issue bus of the arbiter: CPU-side SRAM-like requests, the read and
// write issue slots, and completion pulses from the channel blocks.
// slave = the arbiter, master = its environment.
interface sram_axi_req_arbiter_if;
    logic        inst_req;
    logic        inst_wr;
    logic [1:0]  inst_size;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;

    logic        rd_valid;
    logic [3:0]  rd_id;
    logic [31:0] rd_addr;
    logic [2:0]  rd_size;
    logic        rd_ready;

    logic        wr_valid;
    logic [31:0] wr_addr;
    logic [2:0]  wr_size;
    logic [3:0]  wr_wstrb;
    logic [31:0] wr_wdata;
    logic        wr_ready;

    logic        rd_done;
    logic [3:0]  rd_done_id;
    logic        wr_done;
    logic        busy;

    modport slave (
        input  inst_req, inst_wr, inst_size, inst_addr,
        output inst_addr_ok,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output data_addr_ok,
        output rd_valid, rd_id, rd_addr, rd_size,
        input  rd_ready,
        output wr_valid, wr_addr, wr_size, wr_wstrb, wr_wdata,
        input  wr_ready,
        input  rd_done, rd_done_id, wr_done,
        output busy
    );

    modport master (
        output inst_req, inst_wr, inst_size, inst_addr,
        input  inst_addr_ok,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  data_addr_ok,
        input  rd_valid, rd_id, rd_addr, rd_size,
        output rd_ready,
        input  wr_valid, wr_addr, wr_size, wr_wstrb, wr_wdata,
        output wr_ready,
        output rd_done, rd_done_id, wr_done,
        input  busy
    );
endinterface

// File: rtl/sram_axi_req_arbiter_issue_slot.sv
// issue_slot: one-entry valid/ready holding register. The owner only loads it
// when it is empty or handshaking this cycle, so a load always wins.
module issue_slot #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         ready,
    output logic         valid,
    output logic [W-1:0] data
);
    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    // Next entry state: load replaces, handshake without load empties, else hold.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    // Entry register; reset also clears the payload so outputs read as zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
endmodule

// File: rtl/sram_axi_req_arbiter.sv
// sram_axi_req_arbiter: arbitrates instruction and data SRAM-like requests
// into a read-issue slot and a write-issue slot, tracking reads in flight,
// the single pending write, and starvation of the instruction side.
// Optional feature macro ARB_RAW_ADDR_CMP_EN: when defined, a data read is
// only held behind a pending write to the same 32-bit word; otherwise every
// data read waits for the pending write to complete.
module sram_axi_req_arbiter
    import bridge_pkg::*;
#(
    parameter int RD_MAX     = 2,
    parameter int STARVE_MAX = 4
) (
    input logic                   clk,
    input logic                   resetn,
    sram_axi_req_arbiter_if.slave bus
);
    logic     rd_valid, wr_valid;
    rd_slot_t rd_slot, rd_load_data;
    wr_slot_t wr_slot, wr_load_data;

    logic [1:0] rd_cnt_q, rd_cnt_d;
    logic       wr_pend_q, wr_pend_d;
    logic [2:0] starve_q, starve_d;

    logic rd_free, rd_room, raw_block;
    logic inst_elig, data_rd_elig, data_wr_elig;
    logic inst_gnt, data_gnt, rd_load, wr_load, rd_hs;

`ifdef ARB_RAW_ADDR_CMP_EN
    logic [29:0] wr_pend_addr_q, wr_pend_addr_d;
`endif

    // Eligibility and grant: data beats inst unless inst has been starved.
    always_comb begin
        rd_free = !rd_valid || bus.rd_ready;
        rd_room = ({1'b0, rd_cnt_q} + {2'b00, rd_valid}) < 3'(RD_MAX);
`ifdef ARB_RAW_ADDR_CMP_EN
        raw_block = wr_pend_q && (bus.data_addr[31:2] == wr_pend_addr_q);
`else
        raw_block = wr_pend_q;
`endif
        data_rd_elig = bus.data_req && !bus.data_wr && rd_free && rd_room && !raw_block;
        data_wr_elig = bus.data_req && bus.data_wr && !wr_pend_q;
        inst_elig    = bus.inst_req && rd_free && rd_room;
        inst_gnt     = resetn && inst_elig &&
                       ((starve_q == 3'(STARVE_MAX)) || !(data_rd_elig || data_wr_elig));
        data_gnt     = resetn && !inst_gnt && (data_rd_elig || data_wr_elig);
        rd_load      = inst_gnt || (data_gnt && !bus.data_wr);
        wr_load      = data_gnt && bus.data_wr;
        rd_hs        = rd_valid && bus.rd_ready;

        rd_load_data = '0;
        if (inst_gnt) begin
            rd_load_data.id   = INST_ID;
            rd_load_data.addr = bus.inst_addr;
            rd_load_data.size = axi_size(bus.inst_size);
        end else begin
            rd_load_data.id   = DATA_ID;
            rd_load_data.addr = bus.data_addr;
            rd_load_data.size = axi_size(bus.data_size);
        end
        wr_load_data.addr  = bus.data_addr;
        wr_load_data.size  = axi_size(bus.data_size);
        wr_load_data.wstrb = bus.data_wstrb;
        wr_load_data.wdata = bus.data_wdata;
    end

    // Counter/flag next state: reads in flight, pending write, starvation.
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_pend_d = wr_pend_q;
        starve_d  = starve_q;
        if (rd_hs && !(bus.rd_done && rd_cnt_q != 2'd0)) begin
            rd_cnt_d = rd_cnt_q + 2'd1;
        end else if (!rd_hs && bus.rd_done && rd_cnt_q != 2'd0) begin
            rd_cnt_d = rd_cnt_q - 2'd1;
        end
        // A write grant needs !wr_pend, so it never coincides with a clear.
        if (wr_load) begin
            wr_pend_d = 1'b1;
        end else if (bus.wr_done) begin
            wr_pend_d = 1'b0;
        end
        if (!bus.inst_req || inst_gnt) begin
            starve_d = 3'd0;
        end else if (data_gnt && starve_q != 3'(STARVE_MAX)) begin
            starve_d = starve_q + 3'd1;
        end
`ifdef ARB_RAW_ADDR_CMP_EN
        wr_pend_addr_d = wr_load ? bus.data_addr[31:2] : wr_pend_addr_q;
`endif
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_cnt_q  <= 2'd0;
            wr_pend_q <= 1'b0;
            starve_q  <= 3'd0;
`ifdef ARB_RAW_ADDR_CMP_EN
            wr_pend_addr_q <= '0;
`endif
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_pend_q <= wr_pend_d;
            starve_q  <= starve_d;
`ifdef ARB_RAW_ADDR_CMP_EN
            wr_pend_addr_q <= wr_pend_addr_d;
`endif
        end
    end

    issue_slot #(.W($bits(rd_slot_t))) u_rd_slot (
        .clk       (clk),
        .resetn    (resetn),
        .load      (rd_load),
        .load_data (rd_load_data),
        .ready     (bus.rd_ready),
        .valid     (rd_valid),
        .data      (rd_slot)
    );

    issue_slot #(.W($bits(wr_slot_t))) u_wr_slot (
        .clk       (clk),
        .resetn    (resetn),
        .load      (wr_load),
        .load_data (wr_load_data),
        .ready     (bus.wr_ready),
        .valid     (wr_valid),
        .data      (wr_slot)
    );

    assign bus.inst_addr_ok = inst_gnt;
    assign bus.data_addr_ok = data_gnt;
    assign bus.rd_valid     = rd_valid;
    assign bus.rd_id        = rd_slot.id;
    assign bus.rd_addr      = rd_slot.addr;
    assign bus.rd_size      = rd_slot.size;
    assign bus.wr_valid     = wr_valid;
    assign bus.wr_addr      = wr_slot.addr;
    assign bus.wr_size      = wr_slot.size;
    assign bus.wr_wstrb     = wr_slot.wstrb;
    assign bus.wr_wdata     = wr_slot.wdata;
    assign bus.busy         = rd_valid || wr_valid || (rd_cnt_q != 2'd0) || wr_pend_q;

    // Fetches never write and completions are counted regardless of ID.
    logic unused_ok;
    assign unused_ok = ^{bus.inst_wr, bus.rd_done_id};
endmodule

// File: tb/tb_sram_axi_req_arbiter.sv
// Bench for sram_axi_req_arbiter: directed scenarios plus a randomized run
// against a transaction-level reference model of the arbitration rules.
module tb_sram_axi_req_arbiter;
    import bridge_pkg::*;

    localparam int RD_MAX     = 3;
    localparam int STARVE_MAX = 4;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    sram_axi_req_arbiter_if bus();

    sram_axi_req_arbiter #(.RD_MAX(RD_MAX), .STARVE_MAX(STARVE_MAX)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state (transaction level).
    int          m_rd_v = 0;
    logic [3:0]  m_rd_id = '0;
    logic [31:0] m_rd_addr = '0;
    logic [2:0]  m_rd_size = '0;
    int          m_wr_v = 0;
    logic [31:0] m_wr_addr = '0;
    logic [31:0] m_wr_data = '0;
    int          m_cnt = 0;
    int          m_wr_pend = 0;
    logic [29:0] m_pend_word = '0;
    int          m_starve = 0;
    logic        exp_inst_ok, exp_data_ok;

    // Who may be accepted this cycle, from the current inputs and model state.
    task automatic model_eval();
        bit free, room, raw, d_rd, d_wr, i_el;
        free = (m_rd_v == 0) || bus.rd_ready;
        room = (m_cnt + m_rd_v) < RD_MAX;
`ifdef ARB_RAW_ADDR_CMP_EN
        raw = (m_wr_pend != 0) && (bus.data_addr[31:2] == m_pend_word);
`else
        raw = (m_wr_pend != 0);
`endif
        d_rd = bus.data_req && !bus.data_wr && free && room && !raw;
        d_wr = bus.data_req && bus.data_wr && (m_wr_pend == 0);
        i_el = bus.inst_req && free && room;
        exp_inst_ok = resetn && i_el && (m_starve == STARVE_MAX || !(d_rd || d_wr));
        exp_data_ok = resetn && !exp_inst_ok && (d_rd || d_wr);
    endtask

    // Advance the model across one rising edge.
    task automatic model_step();
        bit hs, hs_w;
        model_eval();
        if (!resetn) begin
            m_rd_v = 0; m_rd_id = '0; m_rd_addr = '0; m_rd_size = '0;
            m_wr_v = 0; m_wr_addr = '0; m_wr_data = '0;
            m_cnt = 0; m_wr_pend = 0; m_pend_word = '0; m_starve = 0;
            return;
        end
        hs   = (m_rd_v != 0) && bus.rd_ready;
        hs_w = (m_wr_v != 0) && bus.wr_ready;
        if (hs) m_cnt++;
        if (bus.rd_done && (m_cnt > 0) && !(hs && m_cnt == 1 && 0)) begin
            if (!(hs && m_cnt == 1 && !bus.rd_done)) m_cnt--;
        end
        if (exp_inst_ok) begin
            m_rd_v = 1; m_rd_id = INST_ID; m_rd_addr = bus.inst_addr; m_rd_size = {1'b0, bus.inst_size};
        end else if (exp_data_ok && !bus.data_wr) begin
            m_rd_v = 1; m_rd_id = DATA_ID; m_rd_addr = bus.data_addr; m_rd_size = {1'b0, bus.data_size};
        end else if (hs) begin
            m_rd_v = 0;
        end
        if (exp_data_ok && bus.data_wr) begin
            m_wr_v = 1; m_wr_addr = bus.data_addr; m_wr_data = bus.data_wdata;
            m_wr_pend = 1; m_pend_word = bus.data_addr[31:2];
        end else begin
            if (hs_w) m_wr_v = 0;
            if (bus.wr_done) m_wr_pend = 0;
        end
        if (!bus.inst_req || exp_inst_ok) m_starve = 0;
        else if (exp_data_ok && m_starve < STARVE_MAX) m_starve++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.inst_req = 0; bus.inst_wr = 0; bus.inst_size = 2'd2; bus.inst_addr = '0;
        bus.data_req = 0; bus.data_wr = 0; bus.data_size = 2'd2; bus.data_wstrb = '0;
        bus.data_addr = '0; bus.data_wdata = '0;
        bus.rd_ready = 0; bus.wr_ready = 0; bus.rd_done = 0; bus.rd_done_id = '0; bus.wr_done = 0;
    endtask

    task automatic do_reset();
        idle();
        resetn = 0;
        tick();
        resetn = 1;
    endtask

    task automatic test_reset();
        idle();
        resetn = 0;
        bus.inst_req = 1; bus.data_req = 1;
        #1;
        checks++;
        if (bus.inst_addr_ok !== 1'b0 || bus.data_addr_ok !== 1'b0) begin
            failures++; $display("FAIL reset_addr_ok: got inst=%b data=%b want 0 0", bus.inst_addr_ok, bus.data_addr_ok);
        end
        tick();
        checks++;
        if ({bus.rd_valid, bus.wr_valid, bus.busy} !== 3'b000 || bus.rd_addr !== 32'd0 || bus.wr_wdata !== 32'd0) begin
            failures++; $display("FAIL reset_state: got rv=%b wv=%b busy=%b ra=%h wd=%h want all 0",
                                 bus.rd_valid, bus.wr_valid, bus.busy, bus.rd_addr, bus.wr_wdata);
        end
        resetn = 1;
        idle();
    endtask

    task automatic test_single_read();
        do_reset();
        bus.inst_req = 1; bus.inst_addr = 32'hBFC0_0000; bus.inst_size = 2'd2; bus.rd_ready = 1;
        #1;
        checks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            failures++; $display("FAIL single_ok: got %b want 1", bus.inst_addr_ok);
        end
        tick();
        bus.inst_req = 0;
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_id !== 4'd0 || bus.rd_addr !== 32'hBFC0_0000 || bus.rd_size !== 3'd2) begin
            failures++; $display("FAIL single_slot: got v=%b id=%h a=%h s=%h want 1 0 bfc00000 2",
                                 bus.rd_valid, bus.rd_id, bus.rd_addr, bus.rd_size);
        end
        tick();
        checks++;
        if (dut.rd_cnt_q !== 2'd1 || bus.rd_valid !== 1'b0) begin
            failures++; $display("FAIL single_cnt_up: got cnt=%0d v=%b want 1 0", dut.rd_cnt_q, bus.rd_valid);
        end
        bus.rd_done = 1;
        tick();
        bus.rd_done = 0;
        checks++;
        if (dut.rd_cnt_q !== 2'd0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL single_cnt_down: got cnt=%0d busy=%b want 0 0", dut.rd_cnt_q, bus.busy);
        end
    endtask

    task automatic test_contention();
        int data_before_inst;
        bit saw_inst;
        do_reset();
        bus.inst_req = 1; bus.inst_addr = 32'h100;
        bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h2000; bus.rd_ready = 1;
        data_before_inst = 0; saw_inst = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.data_addr_ok !== 1'b1 || bus.inst_addr_ok !== 1'b0) begin
                failures++; $display("FAIL contention_data%0d: got d=%b i=%b want 1 0", c, bus.data_addr_ok, bus.inst_addr_ok);
            end
            if (bus.data_addr_ok === 1'b1) data_before_inst++;
            tick();
        end
        #1;
        checks++;
        if (bus.data_addr_ok !== 1'b0 || bus.inst_addr_ok !== 1'b0) begin
            failures++; $display("FAIL contention_full: got d=%b i=%b want 0 0", bus.data_addr_ok, bus.inst_addr_ok);
        end
        tick();
        bus.rd_done = 1;
        for (int c = 0; c < 6 && !saw_inst; c++) begin
            #1;
            model_eval();
            checks++;
            if (bus.data_addr_ok !== exp_data_ok || bus.inst_addr_ok !== exp_inst_ok) begin
                failures++; $display("FAIL contention_room%0d: got d=%b i=%b want %b %b",
                                     c, bus.data_addr_ok, bus.inst_addr_ok, exp_data_ok, exp_inst_ok);
            end
            if (bus.inst_addr_ok === 1'b1) saw_inst = 1;
            else if (bus.data_addr_ok === 1'b1) data_before_inst++;
            tick();
        end
        bus.rd_done = 0;
        checks++;
        if (!saw_inst || data_before_inst != STARVE_MAX) begin
            failures++; $display("FAIL contention_starve: got inst=%0d data_grants=%0d want 1 %0d",
                                 saw_inst, data_before_inst, STARVE_MAX);
        end
        idle();
    endtask

    task automatic test_raw();
        logic [31:0] wd;
        logic        exp_other;
`ifdef ARB_RAW_ADDR_CMP_EN
        exp_other = 1'b1;
`else
        exp_other = 1'b0;
`endif
        do_reset();
        wd = $urandom;
        bus.rd_ready = 1; bus.wr_ready = 1;
        bus.data_req = 1; bus.data_wr = 1; bus.data_addr = 32'h1000; bus.data_wstrb = 4'hF; bus.data_wdata = wd;
        #1;
        checks++;
        if (bus.data_addr_ok !== 1'b1) begin
            failures++; $display("FAIL raw_write_ok: got %b want 1", bus.data_addr_ok);
        end
        tick();
        checks++;
        if (bus.wr_valid !== 1'b1 || bus.wr_addr !== 32'h1000 || bus.wr_wdata !== wd || bus.wr_wstrb !== 4'hF) begin
            failures++; $display("FAIL raw_wr_slot: got v=%b a=%h d=%h s=%h want 1 1000 %h f",
                                 bus.wr_valid, bus.wr_addr, bus.wr_wdata, bus.wr_wstrb, wd);
        end
        bus.data_wr = 0;
        #1;
        checks++;
        if (bus.data_addr_ok !== 1'b0) begin
            failures++; $display("FAIL raw_same_word: got %b want 0", bus.data_addr_ok);
        end
        bus.data_addr = 32'h1004;
        #1;
        checks++;
        if (bus.data_addr_ok !== exp_other) begin
            failures++; $display("FAIL raw_other_word: got %b want %b", bus.data_addr_ok, exp_other);
        end
        tick();
        bus.data_addr = 32'h1000; bus.wr_done = 1;
        #1;
        checks++;
        if (bus.data_addr_ok !== 1'b0) begin
            failures++; $display("FAIL raw_done_cycle: got %b want 0", bus.data_addr_ok);
        end
        tick();
        bus.wr_done = 0;
        #1;
        checks++;
        if (bus.data_addr_ok !== 1'b1) begin
            failures++; $display("FAIL raw_after_done: got %b want 1", bus.data_addr_ok);
        end
        tick();
        idle();
    endtask

    task automatic test_backpressure();
        do_reset();
        bus.inst_req = 1; bus.inst_addr = 32'h4000; bus.rd_ready = 0;
        #1;
        checks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            failures++; $display("FAIL bp_first_ok: got %b want 1", bus.inst_addr_ok);
        end
        tick();
        bus.inst_addr = 32'h4010;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.inst_addr_ok !== 1'b0 || bus.rd_valid !== 1'b1 || bus.rd_addr !== 32'h4000 || bus.rd_id !== 4'd0) begin
                failures++; $display("FAIL bp_hold%0d: got ok=%b v=%b a=%h id=%h want 0 1 4000 0",
                                     c, bus.inst_addr_ok, bus.rd_valid, bus.rd_addr, bus.rd_id);
            end
            tick();
        end
        bus.rd_ready = 1;
        #1;
        checks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            failures++; $display("FAIL bp_drain_ok: got %b want 1", bus.inst_addr_ok);
        end
        tick();
        bus.inst_req = 0;
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 32'h4010) begin
            failures++; $display("FAIL bp_next_slot: got v=%b a=%h want 1 4010", bus.rd_valid, bus.rd_addr);
        end
        idle();
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.inst_req = 1; bus.inst_addr = 32'h80; bus.rd_ready = 0;
        tick();
        bus.inst_req = 0; bus.rd_ready = 1;
        tick();
        bus.inst_req = 1;
        tick();
        bus.inst_req = 0; bus.rd_done = 1;
        tick();
        checks++;
        if (dut.rd_cnt_q !== 2'd1 || bus.rd_valid !== 1'b0) begin
            failures++; $display("FAIL simul_hs_done: got cnt=%0d v=%b want 1 0", dut.rd_cnt_q, bus.rd_valid);
        end
        bus.rd_done = 0; bus.rd_ready = 0; bus.wr_done = 1;
        tick();
        bus.wr_done = 0;
        checks++;
        if (dut.wr_pend_q !== 1'b0 || dut.rd_cnt_q !== 2'd1 || bus.wr_valid !== 1'b0 || bus.busy !== 1'b1) begin
            failures++; $display("FAIL simul_stray_wr_done: got pend=%b cnt=%0d wv=%b busy=%b want 0 1 0 1",
                                 dut.wr_pend_q, dut.rd_cnt_q, bus.wr_valid, bus.busy);
        end
        idle();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.rd_ready = 1; bus.wr_ready = 0;
        bus.inst_req = 1; bus.inst_addr = 32'h500;
        tick();
        bus.inst_req = 0; bus.data_req = 1; bus.data_wr = 0; bus.data_addr = 32'h3000;
        tick();
        bus.data_wr = 1; bus.data_wdata = 32'hCAFE_F00D; bus.data_wstrb = 4'h3;
        tick();
        bus.data_req = 0; bus.inst_req = 1; bus.rd_ready = 0;
        tick();
        bus.inst_req = 0;
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.wr_valid !== 1'b1 || dut.rd_cnt_q !== 2'd2 || dut.wr_pend_q !== 1'b1) begin
            failures++; $display("FAIL midrst_setup: got rv=%b wv=%b cnt=%0d pend=%b want 1 1 2 1",
                                 bus.rd_valid, bus.wr_valid, dut.rd_cnt_q, dut.wr_pend_q);
        end
        resetn = 0; bus.rd_done = 1; bus.wr_done = 1; bus.inst_req = 1;
        #1;
        checks++;
        if (bus.inst_addr_ok !== 1'b0) begin
            failures++; $display("FAIL midrst_ok: got %b want 0", bus.inst_addr_ok);
        end
        tick();
        checks++;
        if ({bus.rd_valid, bus.wr_valid, bus.busy} !== 3'b000 || bus.rd_addr !== 32'd0 || bus.rd_id !== 4'd0 ||
            bus.wr_addr !== 32'd0 || bus.wr_wdata !== 32'd0 || bus.wr_wstrb !== 4'd0) begin
            failures++; $display("FAIL midrst_clear: got rv=%b wv=%b busy=%b ra=%h id=%h wa=%h wd=%h want all 0",
                                 bus.rd_valid, bus.wr_valid, bus.busy, bus.rd_addr, bus.rd_id, bus.wr_addr, bus.wr_wdata);
        end
        resetn = 1; bus.rd_done = 0; bus.wr_done = 0; bus.inst_addr = 32'h600;
        #1;
        checks++;
        if (bus.inst_addr_ok !== 1'b1) begin
            failures++; $display("FAIL midrst_regrant: got %b want 1", bus.inst_addr_ok);
        end
        tick();
        checks++;
        if (bus.rd_valid !== 1'b1 || bus.rd_addr !== 32'h600) begin
            failures++; $display("FAIL midrst_slot: got v=%b a=%h want 1 600", bus.rd_valid, bus.rd_addr);
        end
        idle();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            resetn        = ($urandom_range(0, 59) != 0);
            bus.inst_req  = $urandom_range(0, 1);
            bus.inst_addr = $urandom;
            bus.inst_size = 2'($urandom_range(0, 2));
            bus.data_req  = $urandom_range(0, 1);
            bus.data_wr   = $urandom_range(0, 1);
            case ($urandom_range(0, 2))
                0:       bus.data_addr = 32'h1000;
                1:       bus.data_addr = 32'h1004;
                default: bus.data_addr = 32'h2000;
            endcase
            bus.data_size  = 2'($urandom_range(0, 2));
            bus.data_wstrb = 4'($urandom);
            bus.data_wdata = $urandom;
            bus.rd_ready   = ($urandom_range(0, 3) != 0);
            bus.wr_ready   = ($urandom_range(0, 3) != 0);
            bus.wr_done    = (m_wr_pend != 0) && !(m_wr_v != 0 && !bus.wr_ready) && ($urandom_range(0, 2) == 0);
            bus.rd_done    = ($urandom_range(0, 2) == 0) && (m_cnt > 0);
            #1;
            model_eval();
            checks++;
            if (bus.inst_addr_ok !== exp_inst_ok || bus.data_addr_ok !== exp_data_ok) begin
                failures++; $display("FAIL rand_grant@%0d: got i=%b d=%b want %b %b",
                                     i, bus.inst_addr_ok, bus.data_addr_ok, exp_inst_ok, exp_data_ok);
            end
            tick();
            checks++;
            if (bus.rd_valid !== (m_rd_v != 0) || bus.rd_id !== m_rd_id || bus.rd_addr !== m_rd_addr ||
                bus.rd_size !== m_rd_size || bus.wr_valid !== (m_wr_v != 0) || bus.wr_addr !== m_wr_addr ||
                bus.wr_wdata !== m_wr_data ||
                bus.busy !== ((m_rd_v != 0) || (m_wr_v != 0) || (m_cnt != 0) || (m_wr_pend != 0))) begin
                failures++; $display("FAIL rand_state@%0d: got rv=%b id=%h ra=%h wv=%b wa=%h busy=%b want rv=%0d id=%h ra=%h wv=%0d wa=%h cnt=%0d pend=%0d",
                                     i, bus.rd_valid, bus.rd_id, bus.rd_addr, bus.wr_valid, bus.wr_addr, bus.busy,
                                     m_rd_v, m_rd_id, m_rd_addr, m_wr_v, m_wr_addr, m_cnt, m_wr_pend);
            end
        end
        resetn = 1;
        idle();
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_raw();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
